// File: rtl/jk_excite_counter.sv
// Modulo counter built from a JK register bank: the desired next state is turned into
// per-bit J/K excitation, and the bank applies the JK law to reach it.
module jk_excite_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             carry,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic             carry_nxt;
  logic             err_nxt;

  // Out-of-range states fold back into range: up goes to 0, down goes to MAX_Q.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return (v >= MAX_Q) ? '0 : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
    return ((v == '0) || (v > MAX_Q)) ? MAX_Q : v - WIDTH'(1);
  endfunction

  always_comb begin
    nxt       = q;
    carry_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) nxt = load_val;
      else                            err_nxt = 1'b1;
    end else if (en) begin
      if (up) begin
        nxt       = wrap_inc(q);
        carry_nxt = (q == MAX_Q);
      end else begin
        nxt       = wrap_dec(q);
        carry_nxt = (q == '0);
      end
    end
  end

  // J sets bits that must rise, K clears bits that must fall; never both on one bit.
  assign j_vec = ~q & nxt;
  assign k_vec = q & ~nxt;

  // Register bank stage: JK update law, which lands exactly on nxt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= (j_vec & ~q) | (~k_vec & q);
      carry    <= carry_nxt;
      load_err <= err_nxt;
    end
  end

endmodule
